act_stream_buffer: RTL and testbench

- Sits directly downstream of the PE array in the NPU datapath. Takes the place of the ad-hoc feed-through buffer in the top level.
- On a load strobe it captures all NUM_NEURONS parallel accumulator results and applies optional ReLU.
- It then serialises the stored values one per handshake onto the PE broadcast input (in_ip), which feeds the next layer.

---
 rtl/npu_pkg.sv | 19 +
 rtl/act_argmax_tracker.sv | 49 ++++
 rtl/act_stream_buffer.sv | 131 +++++++++++++
 tb/tb_act_stream_buffer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared NPU definitions: datapath widths, the activation buffer state type,
// and the ReLU helper used when accumulator results are captured.
package npu_pkg;

   localparam int DATA_W      = 16;
   localparam int NUM_NEURONS = 32;
   localparam int IDX_W       = 6;

   typedef enum logic {
      ST_IDLE,
      ST_STREAM
   } state_t;

   // Rectified linear unit on a two's complement value: negatives become zero.
   function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] value);
      return value[DATA_W-1] ? '0 : value;
   endfunction

endpackage

// File: rtl/act_argmax_tracker.sv
// Running signed maximum over the streamed activations. Only present in
// builds with ACT_ARGMAX_EN defined; otherwise this file contributes nothing
// and the buffer ties its argmax outputs to zero.
`ifdef ACT_ARGMAX_EN
module act_argmax_tracker
   import npu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_update,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [DATA_W-1:0] i_val,
   output logic [IDX_W-1:0]  o_maxIdx,
   output logic [DATA_W-1:0] o_maxVal
);

   logic              r_seen;
   logic [IDX_W-1:0]  r_maxIdx;
   logic [DATA_W-1:0] r_maxVal;
   logic              w_better;

   // The first element always wins; later elements must be strictly greater
   // so that ties keep the lower lane index.
   assign w_better = !r_seen || ($signed(i_val) > $signed(r_maxVal));

   // Clear on every accepted load, fold in each transferred element, and
   // otherwise hold the last result until the next accepted load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seen   <= 1'b0;
         r_maxIdx <= '0;
         r_maxVal <= '0;
      end else if (i_clear) begin
         r_seen   <= 1'b0;
         r_maxIdx <= '0;
         r_maxVal <= '0;
      end else if (i_update && w_better) begin
         r_seen   <= 1'b1;
         r_maxIdx <= i_idx;
         r_maxVal <= i_val;
      end
   end

   assign o_maxIdx = r_maxIdx;
   assign o_maxVal = r_maxVal;

endmodule
`endif

// File: rtl/act_stream_buffer.sv
// Activation stream buffer between the PE array and the PE broadcast input.
// Captures all accumulator lanes on load (optionally through ReLU) and then
// streams the first n lanes out one per valid/ready handshake.
// Optional argmax tracking is built only when ACT_ARGMAX_EN is defined.
module act_stream_buffer
   import npu_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          load,
   input  logic [NUM_NEURONS*DATA_W-1:0] acc_flat,
   input  logic                          act_en,
   input  logic [IDX_W-1:0]              num_active,
   output logic [DATA_W-1:0]             out_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          out_last,
   output logic [IDX_W-1:0]              out_idx,
   output logic                          busy,
   output logic                          done,
   output logic                          load_drop,
   output logic [IDX_W-1:0]              max_idx,
   output logic [DATA_W-1:0]             max_val
);

   localparam int PTR_W = $clog2(NUM_NEURONS);

   state_t            r_state;
   logic [DATA_W-1:0] r_store [NUM_NEURONS];
   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  r_count;
   logic              r_done;
   logic              r_drop;

   logic [IDX_W-1:0]  w_clampedCount;
   logic              w_accept;
   logic              w_xfer;
   logic              w_lastBeat;
   logic [DATA_W-1:0] w_curData;

   assign w_clampedCount = (num_active > IDX_W'(NUM_NEURONS)) ? IDX_W'(NUM_NEURONS) : num_active;
   assign w_accept       = load && (r_state == ST_IDLE);
   assign w_xfer         = (r_state == ST_STREAM) && out_ready;
   assign w_lastBeat     = (r_ptr == (r_count - IDX_W'(1)));
   assign w_curData      = r_store[r_ptr[PTR_W-1:0]];

   // Lane storage: written only by an accepted load, so loads arriving while
   // streaming leave the in-flight data untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_NEURONS; k++) begin
            r_store[k] <= '0;
         end
      end else if (w_accept) begin
         for (int k = 0; k < NUM_NEURONS; k++) begin
            r_store[k] <= act_en ? relu(acc_flat[k*DATA_W +: DATA_W])
                                 : acc_flat[k*DATA_W +: DATA_W];
         end
      end
   end

   // Control FSM: IDLE waits for a load, STREAM walks the pointer on each
   // handshake. done and load_drop are single-cycle registered pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_drop <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (load) begin
                  r_count <= w_clampedCount;
                  r_ptr   <= '0;
                  if (w_clampedCount == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_state <= ST_STREAM;
                  end
               end
            end
            ST_STREAM: begin
               if (load) begin
                  r_drop <= 1'b1;
               end
               if (w_xfer) begin
                  if (w_lastBeat) begin
                     r_state <= ST_IDLE;
                     r_ptr   <= '0;
                     r_done  <= 1'b1;
                  end else begin
                     r_ptr <= r_ptr + IDX_W'(1);
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy      = (r_state == ST_STREAM);
   assign out_valid = busy;
   assign out_data  = w_curData;
   assign out_idx   = r_ptr;
   assign out_last  = busy && w_lastBeat;
   assign done      = r_done;
   assign load_drop = r_drop;

`ifdef ACT_ARGMAX_EN
   act_argmax_tracker u_argmax (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_accept),
      .i_update (w_xfer),
      .i_idx    (r_ptr),
      .i_val    (w_curData),
      .o_maxIdx (max_idx),
      .o_maxVal (max_val)
   );
`else
   assign max_idx = '0;
   assign max_val = '0;
`endif

endmodule

// File: tb/tb_act_stream_buffer.sv
// Self-checking bench for act_stream_buffer. A queue-based reference model
// derives the expected stream and argmax from the lane values directly.
module tb_act_stream_buffer;
   import npu_pkg::*;

   logic                          clk = 1'b0;
   logic                          rst;
   logic                          load;
   logic [NUM_NEURONS*DATA_W-1:0] acc_flat;
   logic                          act_en;
   logic [IDX_W-1:0]              num_active;
   logic [DATA_W-1:0]             out_data;
   logic                          out_valid;
   logic                          out_ready;
   logic                          out_last;
   logic [IDX_W-1:0]              out_idx;
   logic                          busy;
   logic                          done;
   logic                          load_drop;
   logic [IDX_W-1:0]              max_idx;
   logic [DATA_W-1:0]             max_val;

   int checkCount = 0;
   int passCount  = 0;

   logic signed [DATA_W-1:0] lanes [NUM_NEURONS];
   logic [DATA_W-1:0]        expData[$];
   int                       expMaxIdx;
   logic [DATA_W-1:0]        expMaxVal;

   act_stream_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .acc_flat   (acc_flat),
      .act_en     (act_en),
      .num_active (num_active),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .out_idx    (out_idx),
      .busy       (busy),
      .done       (done),
      .load_drop  (load_drop),
      .max_idx    (max_idx),
      .max_val    (max_val)
   );

   always #5 clk = ~clk;

   // One comparison: counts it and reports a failure with both values.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
   endtask

   // Reference model: first min(n,32) lanes, ReLU'd if requested; argmax is the
   // first occurrence of the largest signed value.
   task automatic buildModel(input bit actEn, input int numActive);
      int n;
      int best;
      int bestIdx;
      logic [DATA_W-1:0] pattern;
      n = (numActive > NUM_NEURONS) ? NUM_NEURONS : numActive;
      expData.delete();
      best    = 0;
      bestIdx = 0;
      for (int k = 0; k < n; k++) begin
         int v;
         v = int'(lanes[k]);
         if (actEn && v < 0) v = 0;
         pattern = DATA_W'(v);
         expData.push_back(pattern);
         if (k == 0 || v > best) begin
            best    = v;
            bestIdx = k;
         end
      end
`ifdef ACT_ARGMAX_EN
      expMaxIdx = (n == 0) ? 0 : bestIdx;
      expMaxVal = (n == 0) ? '0 : DATA_W'(best);
`else
      expMaxIdx = 0;
      expMaxVal = '0;
`endif
   endtask

   // Drive a load pulse from the current negedge, leaving at the next negedge.
   task automatic applyStimulus(input bit actEn, input int numActive);
      for (int k = 0; k < NUM_NEURONS; k++) begin
         acc_flat[k*DATA_W +: DATA_W] = lanes[k];
      end
      act_en     = actEn;
      num_active = IDX_W'(numActive);
      load       = 1'b1;
      buildModel(actEn, numActive);
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic randomLanes(input int lo, input int hi);
      for (int k = 0; k < NUM_NEURONS; k++) begin
         int v;
         v = lo + int'($urandom_range(0, hi - lo));
         lanes[k] = DATA_W'(v);
      end
   endtask

   // Walk the expected stream; readyMode 0=always, 1=random, 2=1,0,0 pattern.
   // dropBeat >= 0 injects a load during that beat. Ends at the done-cycle negedge.
   task automatic runStream(input int readyMode, input int dropBeat);
      int  beat;
      int  cycles;
      bit  dropPending;
      bit  dropDone;
      bit  rdy;
      beat        = 0;
      cycles      = 0;
      dropPending = 0;
      dropDone    = 0;
      checkOutput("max_idx_cleared", 32'(max_idx), 0);
      checkOutput("max_val_cleared", 32'(max_val), 0);
      while (beat < expData.size() && cycles < 500) begin
         if (dropPending) begin
            load = 1'b0;
            checkOutput("load_drop_pulse", 32'(load_drop), 1);
            dropPending = 0;
         end else if (dropDone) begin
            checkOutput("load_drop_idle", 32'(load_drop), 0);
         end
         checkOutput("out_valid", 32'(out_valid), 1);
         checkOutput("busy", 32'(busy), 1);
         checkOutput("out_data", 32'(out_data), 32'(expData[beat]));
         checkOutput("out_idx", 32'(out_idx), 32'(beat));
         checkOutput("out_last", 32'(out_last), 32'(beat == expData.size() - 1));
         checkOutput("done_mid", 32'(done), 0);
         if (beat == dropBeat && !dropDone) begin
            acc_flat = {NUM_NEURONS{16'h5A5A}};
            load     = 1'b1;
            dropPending = 1;
            dropDone    = 1;
         end
         case (readyMode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (cycles % 3 == 0);
         endcase
         out_ready = rdy;
         @(negedge clk);
         cycles++;
         if (rdy) beat++;
      end
      if (cycles >= 500) checkOutput("stream_timeout", 32'(beat), 32'(expData.size()));
      load      = 1'b0;
      out_ready = 1'b0;
      checkOutput("done_pulse", 32'(done), 1);
      checkOutput("valid_after", 32'(out_valid), 0);
      checkOutput("busy_after", 32'(busy), 0);
      checkOutput("last_after", 32'(out_last), 0);
      checkOutput("max_idx_done", 32'(max_idx), 32'(expMaxIdx));
      checkOutput("max_val_done", 32'(max_val), 32'(expMaxVal));
   endtask

   // One idle cycle after done: pulse gone, argmax still held.
   task automatic finishIdle();
      @(negedge clk);
      checkOutput("done_cleared", 32'(done), 0);
      checkOutput("valid_idle", 32'(out_valid), 0);
      checkOutput("max_idx_hold", 32'(max_idx), 32'(expMaxIdx));
      checkOutput("max_val_hold", 32'(max_val), 32'(expMaxVal));
   endtask

   // Directed sequence of scenarios followed by randomized streams.
   initial begin
      rst        = 1'b1;
      load       = 1'b0;
      act_en     = 1'b0;
      out_ready  = 1'b0;
      acc_flat   = '0;
      num_active = '0;
      repeat (2) @(negedge clk);
      checkOutput("rst_valid", 32'(out_valid), 0);
      checkOutput("rst_busy", 32'(busy), 0);
      checkOutput("rst_done", 32'(done), 0);
      checkOutput("rst_drop", 32'(load_drop), 0);
      checkOutput("rst_data", 32'(out_data), 0);
      checkOutput("rst_idx", 32'(out_idx), 0);
      checkOutput("rst_last", 32'(out_last), 0);
      checkOutput("rst_max_idx", 32'(max_idx), 0);
      checkOutput("rst_max_val", 32'(max_val), 0);
      rst = 1'b0;
      @(negedge clk);

      // ReLU with ready held high, 28 lanes of k-3
      for (int k = 0; k < NUM_NEURONS; k++) lanes[k] = DATA_W'(k - 3);
      applyStimulus(1'b1, 28);
      runStream(0, -1);
      finishIdle();

      // Backpressure, negative values pass through without ReLU
      randomLanes(-30000, 30000);
      for (int k = 0; k < 10; k++) lanes[k] = DATA_W'(k - 10);
      applyStimulus(1'b0, 10);
      runStream(2, -1);
      finishIdle();

      // Dropped load mid-stream, then a load in the done cycle
      randomLanes(-30000, 30000);
      applyStimulus(1'b0, 20);
      runStream(0, 3);
      randomLanes(-30000, 30000);
      applyStimulus(1'b1, 12);
      runStream(1, -1);
      finishIdle();

      // Zero-length stream: done pulse with no valid
      randomLanes(-30000, 30000);
      applyStimulus(1'b0, 0);
      checkOutput("zero_done", 32'(done), 1);
      checkOutput("zero_valid", 32'(out_valid), 0);
      checkOutput("zero_busy", 32'(busy), 0);
      checkOutput("zero_max_idx", 32'(max_idx), 0);
      checkOutput("zero_max_val", 32'(max_val), 0);
      @(negedge clk);
      checkOutput("zero_done_clear", 32'(done), 0);

      // Oversized count clamps to all 32 lanes
      randomLanes(-30000, 30000);
      applyStimulus(1'b1, 40);
      runStream(1, -1);
      finishIdle();

      // Argmax with a tie at the top value
      randomLanes(-20, 8);
      lanes[0] = 16'sd5;
      lanes[1] = 16'sd9;
      lanes[2] = 16'sd2;
      lanes[3] = 16'sd9;
      lanes[4] = -16'sd1;
      applyStimulus(1'b1, 10);
      runStream(0, -1);
      finishIdle();

      // Randomized streams
      repeat (4) begin
         randomLanes(-32768, 32767);
         applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 40)));
         runStream(1, -1);
         finishIdle();
      end

      // Reset mid-stream aborts immediately and clears storage
      randomLanes(1, 30000);
      applyStimulus(1'b0, 32);
      out_ready = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("pre_rst_idx", 32'(out_idx), 5);
      checkOutput("pre_rst_valid", 32'(out_valid), 1);
      #2 rst = 1'b1;
      #1;
      checkOutput("async_valid", 32'(out_valid), 0);
      checkOutput("async_busy", 32'(busy), 0);
      checkOutput("async_data", 32'(out_data), 0);
      checkOutput("async_idx", 32'(out_idx), 0);
      out_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("abort_no_done", 32'(done), 0);
         checkOutput("abort_no_valid", 32'(out_valid), 0);
         checkOutput("abort_storage", 32'(out_data), 0);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
